// File: rtl/stepper_move_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stepper_move_sequencer                                          |
// | Purpose  : Avalon-controlled trapezoidal stepper mover with a target FIFO. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module stepper_move_sequencer #(
  parameter int CLOCK_FREQ_HZ     = 50_000_000,
  parameter int MIN_FREQ_HZ       = 100,
  parameter int RAMP_TICK_CYCLES  = 50_000,
  parameter int STEP_PULSE_CYCLES = 100,
  parameter int DIR_SETUP_CYCLES  = 250,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write,
  input  logic               read,
  input  logic [3:0]         address,
  input  logic signed [31:0] writedata,
  output logic signed [31:0] readdata,
  output logic               step,
  output logic               dir,
  output logic               enable,
  output logic               busy
);

  localparam int          c_MAX_CLAMP  = CLOCK_FREQ_HZ / (2 * STEP_PULSE_CYCLES);
  localparam int          c_PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          c_CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] c_CLK        = 32'(CLOCK_FREQ_HZ);
  localparam logic [31:0] c_MIN        = 32'(MIN_FREQ_HZ);
  localparam logic [31:0] c_MAXF       = 32'(c_MAX_CLAMP);
  localparam logic [31:0] c_TICK_LAST  = 32'(RAMP_TICK_CYCLES - 1);
  localparam logic [31:0] c_PULSE_LAST = 32'(STEP_PULSE_CYCLES - 1);
  localparam logic [31:0] c_SETUP      = 32'(DIR_SETUP_CYCLES);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ACCEL  = 3'd2,
    S_CRUISE = 3'd3,
    S_DECEL  = 3'd4
  } state_t;

  state_t              r_state;
  logic signed [31:0]  r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_overflow;
  logic [31:0]         r_max_freq;
  logic [31:0]         r_accel;
  logic signed [31:0]  r_position;
  logic signed [31:0]  r_target;
  logic [31:0]         r_freq;
  logic [32:0]         r_acc;
  logic [31:0]         r_remaining;
  logic [31:0]         r_ramp_steps;
  logic [31:0]         r_tick_cnt;
  logic [31:0]         r_setup_cnt;
  logic [31:0]         r_pulse_cnt;
  logic                r_load_init;

  logic                w_abort;
  logic                w_status_wr;
  logic                w_push_req;
  logic                w_fifo_full;
  logic                w_pop;
  logic                w_push;
  logic                w_overflow_set;
  logic [31:0]         w_max_clamped;
  logic signed [31:0]  w_delta;
  logic [31:0]         w_delta_abs;
  logic [32:0]         w_acc_sum;
  logic                w_running;
  logic                w_step_fire;
  logic                w_tick;
  logic [32:0]         w_freq_up;
  logic [31:0]         w_freq_up_sat;
  logic [32:0]         w_freq_floor;
  logic [31:0]         w_freq_dn;
  logic [31:0]         w_freq_cap;
  logic [2:0]          w_cnt3;
  logic [2:0]          w_state_bits;

  function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
    if (p == c_PTR_LAST) return '0;
    return p + c_PTR_W'(1);
  endfunction

  // Abort wins over everything in the same cycle, including a push.
  assign w_status_wr    = write && (address == 4'h3);
  assign w_abort        = w_status_wr && writedata[0];
  assign w_push_req     = write && (address == 4'h0);
  assign w_fifo_full    = (r_count == c_CNT_FULL);
  assign w_pop          = (r_state == S_IDLE) && (r_count != '0) && !w_abort;
  assign w_push         = w_push_req && !w_abort && (!w_fifo_full || w_pop);
  assign w_overflow_set = w_push_req && !w_abort && w_fifo_full && !w_pop;

  always_comb begin
    w_max_clamped = 32'(writedata);
    if (writedata < MIN_FREQ_HZ)
      w_max_clamped = c_MIN;
    else if (writedata > c_MAX_CLAMP)
      w_max_clamped = c_MAXF;
  end

  assign w_delta     = r_target - r_position;
  assign w_delta_abs = w_delta[31] ? 32'(-w_delta) : 32'(w_delta);

  assign w_running   = (r_state == S_ACCEL) || (r_state == S_CRUISE) || (r_state == S_DECEL);
  assign w_acc_sum   = r_acc + {1'b0, r_freq};
  assign w_step_fire = w_running && (r_remaining != '0) && (w_acc_sum >= {1'b0, c_CLK});
  assign w_tick      = (r_tick_cnt == c_TICK_LAST);

  assign w_freq_up     = {1'b0, r_freq} + {1'b0, r_accel};
  assign w_freq_up_sat = (w_freq_up >= {1'b0, r_max_freq}) ? r_max_freq : w_freq_up[31:0];
  assign w_freq_floor  = {1'b0, c_MIN} + {1'b0, r_accel};
  assign w_freq_dn     = ({1'b0, r_freq} >= w_freq_floor) ? (r_freq - r_accel) : c_MIN;
  assign w_freq_cap    = (r_freq > r_max_freq) ? r_max_freq : r_freq;

  assign w_cnt3       = (r_count > c_CNT_W'(7)) ? 3'd7 : 3'(r_count);
  assign w_state_bits = r_state;

  always_comb begin
    readdata = '0;
    case (address)
      4'h0:    readdata = r_target;
      4'h1:    readdata = $signed(r_max_freq);
      4'h2:    readdata = $signed(r_accel);
      4'h3:    readdata = $signed({24'd0, w_state_bits, r_overflow, busy, w_cnt3});
      4'h4:    readdata = r_position;
      default: readdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_max_freq   <= 32'd10_000;
      r_accel      <= 32'd100;
      r_position   <= '0;
      r_target     <= '0;
      r_freq       <= '0;
      r_acc        <= '0;
      r_remaining  <= '0;
      r_ramp_steps <= '0;
      r_tick_cnt   <= '0;
      r_setup_cnt  <= '0;
      r_pulse_cnt  <= '0;
      r_load_init  <= 1'b0;
      step         <= 1'b0;
      dir          <= 1'b0;
      enable       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 32'd1;

      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: ;
      endcase

      if (w_overflow_set)
        r_overflow <= 1'b1;
      else if (w_status_wr && writedata[1])
        r_overflow <= 1'b0;

      if (write && (address == 4'h1)) r_max_freq <= w_max_clamped;
      if (write && (address == 4'h2)) r_accel    <= writedata;
      if (write && (address == 4'h4) && (r_state == S_IDLE)) r_position <= writedata;

      if (r_pulse_cnt != '0)
        r_pulse_cnt <= r_pulse_cnt - 32'd1;
      else
        step <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_target    <= r_fifo[r_rd_ptr];
            r_load_init <= 1'b1;
            r_state     <= S_LOAD;
            busy        <= 1'b1;
            enable      <= 1'b1;
          end
        end

        S_LOAD: begin
          if (r_load_init) begin
            r_load_init <= 1'b0;
            if (w_delta == '0) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              enable  <= 1'b0;
            end else begin
              dir          <= !w_delta[31];
              r_remaining  <= w_delta_abs;
              r_freq       <= c_MIN;
              r_ramp_steps <= '0;
              r_acc        <= '0;
              r_setup_cnt  <= c_SETUP;
            end
          end else if (r_setup_cnt == '0) begin
            r_state    <= S_ACCEL;
            r_tick_cnt <= '0;
          end else begin
            r_setup_cnt <= r_setup_cnt - 32'd1;
          end
        end

        S_ACCEL, S_CRUISE, S_DECEL: begin
          // Phase accumulator: one step each time the running sum crosses the clock rate.
          if (w_step_fire) begin
            r_acc       <= w_acc_sum - {1'b0, c_CLK};
            r_remaining <= r_remaining - 32'd1;
            r_position  <= dir ? r_position + 32'sd1 : r_position - 32'sd1;
            step        <= 1'b1;
            r_pulse_cnt <= c_PULSE_LAST;
            if (r_state == S_ACCEL) r_ramp_steps <= r_ramp_steps + 32'd1;
          end else if (r_remaining != '0) begin
            r_acc <= w_acc_sum;
          end

          if (r_state == S_DECEL) begin
            if (w_tick) r_freq <= w_freq_dn;
            if (r_remaining == '0) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              enable  <= 1'b0;
            end
          end else begin
            if (w_tick) r_freq <= (r_state == S_ACCEL) ? w_freq_up_sat : w_freq_cap;
            if (r_remaining <= r_ramp_steps)
              r_state <= S_DECEL;
            else if ((r_state == S_ACCEL) && (r_freq == r_max_freq))
              r_state <= S_CRUISE;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      if (w_abort) begin
        r_state     <= S_IDLE;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_freq      <= '0;
        r_acc       <= '0;
        r_remaining <= '0;
        r_pulse_cnt <= '0;
        r_load_init <= 1'b0;
        step        <= 1'b0;
        busy        <= 1'b0;
        enable      <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stepper_move_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stepper_move_sequencer                                       |
// | Purpose  : Directed and randomized self-checking bench for the sequencer.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module tb_stepper_move_sequencer;

  localparam int CLK_HZ = 1_000_000;
  localparam int MIN_HZ = 10_000;
  localparam int RAMP   = 50;
  localparam int PULSE  = 10;
  localparam int SETUP  = 25;
  localparam int DEPTH  = 4;
  localparam int MAXC   = CLK_HZ / (2 * PULSE);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               write = 1'b0;
  logic               read = 1'b0;
  logic [3:0]         address = 4'h3;
  logic signed [31:0] writedata = '0;
  logic signed [31:0] readdata;
  logic               step, dir, enable, busy;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  int     pulses = 0;
  int     bad_width = 0;
  int     dir_err = 0;
  longint rise_cyc = 0;
  logic   prev_step = 1'b0;
  bit     exp_dir = 1'b0;
  bit     chk_dir = 1'b0;
  int     exp_pos = 0;

  stepper_move_sequencer #(
    .CLOCK_FREQ_HZ    (CLK_HZ),
    .MIN_FREQ_HZ      (MIN_HZ),
    .RAMP_TICK_CYCLES (RAMP),
    .STEP_PULSE_CYCLES(PULSE),
    .DIR_SETUP_CYCLES (SETUP),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .read     (read),
    .address  (address),
    .writedata(writedata),
    .readdata (readdata),
    .step     (step),
    .dir      (dir),
    .enable   (enable),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse observer: counts rising edges, measures high time, checks dir at each step.
  always @(negedge clk) begin
    if (step === 1'b1 && prev_step !== 1'b1) begin
      pulses++;
      rise_cyc = cyc;
      if (chk_dir && dir !== exp_dir) dir_err++;
    end
    if (step !== 1'b1 && prev_step === 1'b1 && (cyc - rise_cyc) != PULSE) bad_width++;
    prev_step = step;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_ge(input string tag, input longint obs, input longint lo);
    checks++;
    assert (obs >= lo) else begin
      failures++;
      $error("FAIL %s observed=%0d expected>=%0d", tag, obs, lo);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic signed [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; address = 4'h3;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic signed [31:0] v);
    @(negedge clk);
    address = a; read = 1'b1;
    #1 v = readdata;
    read = 1'b0; address = 4'h3;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    bit done = 1'b0;
    address = 4'h3;
    while (!done && n < budget) begin
      @(negedge clk);
      #1 n++;
      if (busy === 1'b0 && readdata[2:0] === 3'd0 && step === 1'b0) done = 1'b1;
    end
    check({tag, "_finished"}, done, 1);
  endtask

  task automatic wait_step(output bit found, input int budget);
    int n = 0;
    found = 1'b0;
    while (!found && n < budget) begin
      @(negedge clk);
      #1 n++;
      if (step === 1'b1) found = 1'b1;
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clamp_f(input int v);
    if (v < MIN_HZ) return MIN_HZ;
    if (v > MAXC) return MAXC;
    return v;
  endfunction

  task automatic do_move(input string tag, input int target, input int budget);
    int delta, p0, bw0, de0;
    logic signed [31:0] v;
    delta = target - exp_pos;
    p0 = pulses; bw0 = bad_width; de0 = dir_err;
    exp_dir = (delta > 0);
    chk_dir = (delta != 0);
    bus_write(4'h0, target);
    wait_done(tag, budget);
    check({tag, "_pulses"}, pulses - p0, iabs(delta));
    check({tag, "_width_errs"}, bad_width - bw0, 0);
    check({tag, "_dir_errs"}, dir_err - de0, 0);
    if (delta != 0) check({tag, "_dir"}, dir, exp_dir);
    bus_read(4'h4, v);
    check({tag, "_position"}, v, target);
    exp_pos = target;
    chk_dir = 1'b0;
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [31:0] v;
    bit found;
    int p0, bw0, n, r, t;
    longint push_cyc;
    int tq[5];

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_step", step, 0);
    check("rst_busy", busy, 0);
    check("rst_enable", enable, 0);
    check("rst_dir", dir, 0);
    reset = 1'b1;
    bus_read(4'h3, v); check("rst_status", v, 0);
    bus_read(4'h4, v); check("rst_position", v, 0);
    bus_read(4'h0, v); check("rst_target", v, 0);
    bus_read(4'h1, v); check("rst_max_freq", v, 10_000);
    bus_read(4'h2, v); check("rst_accel", v, 100);
    bus_read(4'h7, v); check("unmapped_read", v, 0);

    // Move +10 with dir-setup latency measurement
    p0 = pulses; bw0 = bad_width;
    exp_dir = 1'b1; chk_dir = 1'b1;
    bus_write(4'h0, 10);
    push_cyc = cyc;
    wait_step(found, 3000);
    check("m10_first_step_seen", found, 1);
    check_ge("m10_dir_setup", cyc - push_cyc, SETUP);
    check("m10_enable", enable, 1);
    check("m10_busy", busy, 1);
    wait_done("m10", 5000);
    check("m10_pulses", pulses - p0, 10);
    check("m10_width_errs", bad_width - bw0, 0);
    check("m10_dir", dir, 1);
    bus_read(4'h4, v); check("m10_position", v, 10);
    exp_pos = 10; chk_dir = 1'b0;

    do_move("m_neg5", 5, 5000);

    // Faster profile, then overflow with queued moves
    bus_write(4'h1, 50_000);
    bus_write(4'h2, 5_000);
    bus_read(4'h1, v); check("max_freq_50k", v, 50_000);
    p0 = pulses; bw0 = bad_width;
    bus_write(4'h0, 1000);
    n = 0;
    while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    tq = '{1010, 990, 1020, 1000, 3000};
    for (int i = 0; i < 5; i++) bus_write(4'h0, tq[i]);
    bus_read(4'h3, v);
    check("ovf_count", v[2:0], 4);
    check("ovf_flag", v[4], 1);
    check("ovf_busy_bit", v[3], 1);
    wait_done("ovf_moves", 60_000);
    check("ovf_pulses", pulses - p0, (1000 - 5) + 10 + 20 + 30 + 20);
    check("ovf_width_errs", bad_width - bw0, 0);
    bus_read(4'h4, v); check("ovf_position", v, 1000);
    exp_pos = 1000;
    bus_write(4'h3, 32'sd2);
    bus_read(4'h3, v); check("ovf_cleared", v[4], 0);

    // Abort after 20 steps, with queued entries to flush
    bus_write(4'h4, 0);
    bus_read(4'h4, v); check("pos_load", v, 0);
    exp_pos = 0;
    p0 = pulses;
    bus_write(4'h0, 100_000);
    bus_write(4'h0, 7);
    bus_write(4'h0, 8);
    n = 0;
    while (pulses - p0 < 20 && n < 20_000) begin @(negedge clk); #1 n++; end
    check("abort_reach20", pulses - p0, 20);
    address = 4'h3; writedata = 32'sd1; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    #1;
    check("abort_step_low", step, 0);
    check("abort_busy", busy, 0);
    check("abort_enable", enable, 0);
    check("abort_state", readdata[7:5], 0);
    check("abort_count", readdata[2:0], 0);
    repeat (300) @(negedge clk);
    check("abort_no_more_steps", pulses - p0, 20);
    bus_read(4'h4, v); check("abort_position", v, 20);
    exp_pos = 20;

    // Position write is ignored while a move runs
    p0 = pulses;
    bus_write(4'h0, 30);
    n = 0;
    while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    bus_write(4'h4, 500);
    wait_done("pos_ignored", 5000);
    bus_read(4'h4, v); check("pos_ignored_position", v, 30);
    check("pos_ignored_pulses", pulses - p0, 10);
    exp_pos = 30;

    // Zero-length move
    p0 = pulses;
    bus_write(4'h0, 30);
    repeat (2) @(negedge clk);
    check("zero_busy_low", busy, 0);
    repeat (100) @(negedge clk);
    check("zero_pulses", pulses - p0, 0);
    bus_read(4'h3, v); check("zero_count", v[2:0], 0);
    bus_read(4'h4, v); check("zero_position", v, 30);

    // max_freq clamping
    bus_write(4'h1, 1_000_000);
    bus_read(4'h1, v); check("max_clamp_hi", v, MAXC);
    bus_write(4'h1, 50);
    bus_read(4'h1, v); check("max_clamp_lo", v, MIN_HZ);
    for (int i = 0; i < 4; i++) begin
      r = int'($urandom_range(0, 120_000));
      if ($urandom_range(0, 3) == 0) r = -r;
      bus_write(4'h1, r);
      bus_read(4'h1, v); check("max_clamp_rand", v, clamp_f(r));
    end

    // Randomized moves against the target/position model
    for (int i = 0; i < 4; i++) begin
      r = int'($urandom_range(20_000, 70_000));
      bus_write(4'h1, r);
      t = int'($urandom_range(1_000, 20_000));
      bus_write(4'h2, t);
      bus_read(4'h2, v); check("accel_rw", v, t);
      t = exp_pos + int'($urandom_range(0, 80)) - 40;
      do_move("rand_move", t, 10_000);
    end

    // Reset asserted mid-pulse
    bus_write(4'h0, exp_pos + 50);
    wait_step(found, 5000);
    check("mid_pulse_step_seen", found, 1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_pulse_reset_step", step, 0);
    check("mid_pulse_reset_busy", busy, 0);
    reset = 1'b1;
    bus_read(4'h4, v); check("mid_pulse_reset_position", v, 0);
    bus_read(4'h3, v); check("mid_pulse_reset_status", v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
